// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master memory arbiter.
//   arb_state_e       : arbiter FSM state encoding (2-bit)
//   ERR_RDATA_DEFAULT : read data returned to a master whose access is aborted
//   WAIT_CNT_W        : width of the per-grant wait counter
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_ABORT  = 2'd3
  } arb_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int unsigned WAIT_CNT_W        = 8;

endpackage

// File: rtl/mem_arbiter_2m_if.sv
// Native valid/ready memory bus (picorv32 style).
//   mem_valid / mem_addr / mem_wdata / mem_wstrb : request, driven by the initiator
//   mem_ready / mem_rdata                        : one-cycle completion and read data, driven by the target
// Modports:
//   master : the initiating side (a CPU, a DMA, or the arbiter towards the slave bus)
//   slave  : the responding side (a peripheral, or the arbiter towards each master)
interface mem_arbiter_2m_if;

  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;   // 4'b0000 means read
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_2m.sv
// Two-master round-robin arbiter onto a single shared slave bus.
//   clk         : single clock, rising edge
//   resetn      : asynchronous active-low reset
//   m0          : master 0 port (CPU), arbiter is the responder
//   m1          : master 1 port (debug/DMA), arbiter is the responder
//   s           : shared slave bus, arbiter is the initiator
//   err_timeout : sticky, set when any access is aborted for lack of s.mem_ready
//   err_master  : index of the master whose access was last aborted
// A request is granted on the clock edge after it is seen in IDLE; while granted,
// the request and the response paths are pure wires. A grant that waits
// TIMEOUT_CYCLES cycles without s.mem_ready is aborted: the master gets one
// ready pulse carrying ERR_RDATA and the sticky error is raised.
module mem_arbiter_2m
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,   // legal range 1..255
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  mem_arbiter_2m_if.slave  m0,
  mem_arbiter_2m_if.slave  m1,
  mem_arbiter_2m_if.master s,
  output logic             err_timeout,
  output logic             err_master
);

  // The counter holds the number of wait cycles already completed, so the
  // last permitted wait cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e            state;
  arb_state_e            state_nxt;
  logic                  last;          // master served (or aborted) most recently
  logic [WAIT_CNT_W-1:0] wait_cnt;

  logic in_grant;
  logic grant_idx;
  logic grant_valid;
  logic done;
  logic timeout;

  assign in_grant    = (state == ST_GRANT0) || (state == ST_GRANT1);
  assign grant_idx   = (state == ST_GRANT1);
  assign grant_valid = grant_idx ? m1.mem_valid : m0.mem_valid;
  assign done        = in_grant && grant_valid && s.mem_ready;
  // Gated by !s.mem_ready so a completion on the final wait cycle wins over the abort.
  assign timeout     = in_grant && grant_valid && !s.mem_ready && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the
    // case leaves one unassigned and infers a latch.
    state_nxt    = state;
    s.mem_valid  = 1'b0;
    s.mem_addr   = '0;
    s.mem_wdata  = '0;
    s.mem_wstrb  = '0;
    m0.mem_ready = 1'b0;
    m0.mem_rdata = '0;
    m1.mem_ready = 1'b0;
    m1.mem_rdata = '0;

    case (state)
      ST_IDLE: begin
        // Round robin: on contention the master not served last goes first.
        if (m0.mem_valid && m1.mem_valid) state_nxt = last ? ST_GRANT0 : ST_GRANT1;
        else if (m0.mem_valid)            state_nxt = ST_GRANT0;
        else if (m1.mem_valid)            state_nxt = ST_GRANT1;
      end

      ST_GRANT0, ST_GRANT1: begin
        if (grant_idx) begin
          s.mem_valid  = m1.mem_valid;
          s.mem_addr   = m1.mem_addr;
          s.mem_wdata  = m1.mem_wdata;
          s.mem_wstrb  = m1.mem_wstrb;
          m1.mem_ready = s.mem_ready;
          m1.mem_rdata = s.mem_rdata;
        end else begin
          s.mem_valid  = m0.mem_valid;
          s.mem_addr   = m0.mem_addr;
          s.mem_wdata  = m0.mem_wdata;
          s.mem_wstrb  = m0.mem_wstrb;
          m0.mem_ready = s.mem_ready;
          m0.mem_rdata = s.mem_rdata;
        end
        // A master withdrawing its request is illegal but must not wedge the bus.
        if (!grant_valid || s.mem_ready) state_nxt = ST_IDLE;
        else if (timeout)                state_nxt = ST_ABORT;
      end

      ST_ABORT: begin
        // last was loaded with the aborted master on entry.
        if (last) begin
          m1.mem_ready = 1'b1;
          m1.mem_rdata = ERR_RDATA;
        end else begin
          m0.mem_ready = 1'b1;
          m0.mem_rdata = ERR_RDATA;
        end
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: last resets to 1 so that master 0 wins the first contention.
    if (!resetn) begin
      state       <= ST_IDLE;
      last        <= 1'b1;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      err_master  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here samples
      // values from before this edge regardless of statement order.
      state <= state_nxt;

      if (done || timeout) last <= grant_idx;

      if (timeout) begin
        err_timeout <= 1'b1;
        err_master  <= grant_idx;
      end

      // Staying in the same grant state only happens on a wait cycle.
      if (in_grant && (state_nxt == state)) wait_cnt <= wait_cnt + 1'b1;
      else                                  wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2m.sv
// Self-checking bench for mem_arbiter_2m (TIMEOUT_CYCLES = 4).
// A transaction-level model tracks who owns the slave bus, how long the owner
// has waited and the sticky error state; a scoreboard process compares every
// DUT output against it on each falling edge. Directed scenarios with literal
// expectations run first, then randomized traffic with varying slave latency.
module tb_mem_arbiter_2m;
  import mem_bus_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        resetn;
  logic [1:0]  mv;
  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic [3:0]  ms [2];
  logic        sr;
  logic [31:0] srd;
  logic        err_timeout;
  logic        err_master;

  mem_arbiter_2m_if m0_bus ();
  mem_arbiter_2m_if m1_bus ();
  mem_arbiter_2m_if s_bus ();

  assign m0_bus.mem_valid = mv[0];
  assign m0_bus.mem_addr  = ma[0];
  assign m0_bus.mem_wdata = md[0];
  assign m0_bus.mem_wstrb = ms[0];
  assign m1_bus.mem_valid = mv[1];
  assign m1_bus.mem_addr  = ma[1];
  assign m1_bus.mem_wdata = md[1];
  assign m1_bus.mem_wstrb = ms[1];
  assign s_bus.mem_ready  = sr;
  assign s_bus.mem_rdata  = srd;

  mem_arbiter_2m #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m0          (m0_bus.slave),
    .m1          (m1_bus.slave),
    .s           (s_bus.master),
    .err_timeout (err_timeout),
    .err_master  (err_master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- checking
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  rdy;
    logic [31:0] rd1;
    logic [31:0] rd0;
    logic        err_t;
    logic        err_m;
  } obs_t;

  // Read data only means something while the matching ready is high.
  function automatic obs_t tidy(input obs_t o);
    obs_t t = o;
    if (!t.rdy[0]) t.rd0 = '0;
    if (!t.rdy[1]) t.rd1 = '0;
    return t;
  endfunction

  function automatic obs_t dut_obs();
    obs_t a;
    a.s_valid = s_bus.mem_valid;
    a.s_addr  = s_bus.mem_addr;
    a.s_wdata = s_bus.mem_wdata;
    a.s_wstrb = s_bus.mem_wstrb;
    a.rdy     = {m1_bus.mem_ready, m0_bus.mem_ready};
    a.rd0     = m0_bus.mem_rdata;
    a.rd1     = m1_bus.mem_rdata;
    a.err_t   = err_timeout;
    a.err_m   = err_master;
    return tidy(a);
  endfunction

  // ---------------------------------------------------------------- model
  int owner;          // master holding the bus this cycle, -1 if none
  int abort_for;      // master receiving the error response this cycle
  bit abort_pending;  // this cycle is the error-response cycle
  int waited;         // cycles the owner has waited without slave ready
  int last_served;
  bit sticky;
  bit err_idx;
  bit ready_seen [2];

  function automatic void model_reset();
    owner         = -1;
    abort_for     = 0;
    abort_pending = 1'b0;
    waited        = 0;
    last_served   = 1;
    sticky        = 1'b0;
    err_idx       = 1'b0;
  endfunction

  function automatic obs_t model_expect();
    obs_t e = '0;
    e.err_t = sticky;
    e.err_m = err_idx;
    if (owner >= 0) begin
      e.s_valid    = mv[owner];
      e.s_addr     = ma[owner];
      e.s_wdata    = md[owner];
      e.s_wstrb    = ms[owner];
      e.rdy[owner] = sr;
      if (owner == 0) e.rd0 = srd;
      else            e.rd1 = srd;
    end else if (abort_pending) begin
      e.rdy[abort_for] = 1'b1;
      if (abort_for == 0) e.rd0 = ERR_RDATA_DEFAULT;
      else                e.rd1 = ERR_RDATA_DEFAULT;
    end
    return tidy(e);
  endfunction

  // What the clock edge at the end of this cycle does to bus ownership.
  function automatic void model_advance();
    if (abort_pending) begin
      abort_pending = 1'b0;
    end else if (owner < 0) begin
      waited = 0;
      if (mv[0] && mv[1]) owner = 1 - last_served;
      else if (mv[0])     owner = 0;
      else if (mv[1])     owner = 1;
    end else if (!mv[owner]) begin
      owner = -1;
    end else if (sr) begin
      last_served = owner;
      owner       = -1;
    end else begin
      waited++;
      if (waited >= TO) begin
        abort_pending = 1'b1;
        abort_for     = owner;
        sticky        = 1'b1;
        err_idx       = (owner == 1);
        last_served   = owner;
        owner         = -1;
      end
    end
  endfunction

  initial begin : scoreboard
    model_reset();
    forever begin
      @(negedge clk);
      if (!resetn) begin
        model_reset();
        check("reset_outputs", dut_obs(), model_expect());
      end else begin
        check("cycle_outputs", dut_obs(), model_expect());
        if (m0_bus.mem_ready) ready_seen[0] = 1'b1;
        if (m1_bus.mem_ready) ready_seen[1] = 1'b1;
        model_advance();
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] st);
    mv[i] = v;
    ma[i] = a;
    md[i] = d;
    ms[i] = st;
  endtask

  task automatic new_req(input int i);
    logic [3:0] st;
    st = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
    set_m(i, 1'b1, $urandom, $urandom, st);
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, '0, '0, '0);
    sr  = 1'b0;
    srd = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  int pct;

  initial begin : main
    resetn = 1'b0;
    idle_all();
    ready_seen[0] = 1'b0;
    ready_seen[1] = 1'b0;

    // Reset state.
    look();
    check("rst_s_valid", s_bus.mem_valid, 1'b0);
    check("rst_ready", {m1_bus.mem_ready, m0_bus.mem_ready}, 2'b00);
    check("rst_err", {err_timeout, err_master}, 2'b00);
    tick();
    resetn = 1'b1;

    // Single master write, slave ready on the first grant cycle.
    set_m(0, 1'b1, 32'h0000_0100, 32'h0000_00A5, 4'hF);
    look();
    check("wr_latency_s_valid0", s_bus.mem_valid, 1'b0);
    tick();
    sr = 1'b1;
    look();
    check("wr_s_valid", s_bus.mem_valid, 1'b1);
    check("wr_s_wdata", s_bus.mem_wdata, 32'h0000_00A5);
    check("wr_s_wstrb", s_bus.mem_wstrb, 4'hF);
    check("wr_ready", {m1_bus.mem_ready, m0_bus.mem_ready}, 2'b01);
    tick();
    idle_all();
    look();
    check("wr_ready_single", {m1_bus.mem_ready, m0_bus.mem_ready}, 2'b00);
    tick();

    // Contention from reset: m0, m1, m0.
    do_reset();
    set_m(0, 1'b1, 32'h0000_0010, 32'h1, 4'hF);
    set_m(1, 1'b1, 32'h0000_0020, 32'h2, 4'hF);
    sr = 1'b1;
    tick();
    look();
    check("rr_first_addr", s_bus.mem_addr, 32'h0000_0010);
    check("rr_first_ready", {m1_bus.mem_ready, m0_bus.mem_ready}, 2'b01);
    tick();
    set_m(0, 1'b1, 32'h0000_0014, 32'h3, 4'hF);
    tick();
    look();
    check("rr_second_addr", s_bus.mem_addr, 32'h0000_0020);
    check("rr_second_ready", {m1_bus.mem_ready, m0_bus.mem_ready}, 2'b10);
    tick();
    set_m(1, 1'b1, 32'h0000_0024, 32'h4, 4'hF);
    tick();
    look();
    check("rr_third_addr", s_bus.mem_addr, 32'h0000_0014);
    check("rr_third_ready", {m1_bus.mem_ready, m0_bus.mem_ready}, 2'b01);
    tick();
    idle_all();
    tick();

    // m1 read returning data.
    set_m(1, 1'b1, 32'h0000_0040, 32'h0, 4'h0);
    tick();
    sr  = 1'b1;
    srd = 32'h1234_5678;
    look();
    check("rd_wstrb", s_bus.mem_wstrb, 4'h0);
    check("rd_ready", {m1_bus.mem_ready, m0_bus.mem_ready}, 2'b10);
    check("rd_rdata", m1_bus.mem_rdata, 32'h1234_5678);
    tick();
    idle_all();
    tick();

    // Ready arrives on the last permitted wait cycle: completion wins.
    set_m(0, 1'b1, 32'h0000_0050, 32'h0, 4'h0);
    for (int c = 1; c < TO; c++) begin
      tick();
      look();
      check("race_wait_ready", m0_bus.mem_ready, 1'b0);
    end
    tick();
    sr  = 1'b1;
    srd = 32'h5555_AAAA;
    look();
    check("race_ready", m0_bus.mem_ready, 1'b1);
    check("race_rdata", m0_bus.mem_rdata, 32'h5555_AAAA);
    tick();
    idle_all();
    look();
    check("race_no_err", err_timeout, 1'b0);
    tick();

    // m0 timeout: slave never ready.
    set_m(0, 1'b1, 32'h0000_0080, 32'h0, 4'h0);
    for (int c = 1; c <= TO; c++) begin
      tick();
      look();
    end
    check("to_last_wait_valid", s_bus.mem_valid, 1'b1);
    check("to_last_wait_err", err_timeout, 1'b0);
    tick();
    look();
    check("to_abort_s_valid", s_bus.mem_valid, 1'b0);
    check("to_abort_ready", {m1_bus.mem_ready, m0_bus.mem_ready}, 2'b01);
    check("to_abort_rdata", m0_bus.mem_rdata, 32'hDEAD_BEEF);
    check("to_abort_err", {err_timeout, err_master}, 2'b10);
    tick();
    idle_all();
    look();
    check("to_sticky", err_timeout, 1'b1);
    tick();

    // m1 timeout updates the error index.
    set_m(1, 1'b1, 32'h0000_0090, 32'h0, 4'h0);
    for (int c = 0; c <= TO; c++) tick();
    look();
    check("to1_abort_ready", {m1_bus.mem_ready, m0_bus.mem_ready}, 2'b10);
    check("to1_abort_err", {err_timeout, err_master}, 2'b11);
    tick();
    idle_all();
    tick();

    // Reset while m1 holds the bus.
    set_m(1, 1'b1, 32'h0000_0200, 32'h7, 4'hF);
    tick();
    look();
    check("rg_granted", s_bus.mem_valid, 1'b1);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    sr     = 1'b1;
    set_m(0, 1'b1, 32'h0000_0300, 32'h8, 4'hF);
    #1;
    check("rg_s_valid_drop", s_bus.mem_valid, 1'b0);
    check("rg_no_ready", {m1_bus.mem_ready, m0_bus.mem_ready}, 2'b00);
    check("rg_err_clear", err_timeout, 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    look();
    check("rg_m0_wins", s_bus.mem_addr, 32'h0000_0300);
    check("rg_m0_ready", {m1_bus.mem_ready, m0_bus.mem_ready}, 2'b01);
    tick();
    idle_all();
    tick();

    // Randomized traffic against the model.
    pct = 40;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (cyc % 700 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 5;
          1:       pct = 40;
          default: pct = 90;
        endcase
      end
      if (cyc == 2000) resetn = 1'b0;
      if (cyc == 2002) resetn = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (mv[i]) begin
          if (ready_seen[i]) begin
            if ($urandom_range(0, 1) == 1) new_req(i);
            else                           mv[i] = 1'b0;
          end else if ($urandom_range(0, 63) == 0) begin
            mv[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          new_req(i);
        end
        ready_seen[i] = 1'b0;
      end
      sr  = ($urandom_range(0, 99) < pct);
      srd = $urandom;
    end

    tick();
    idle_all();
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_2m.md
MEM_ARBITER_2M -- requirements
Module: mem_arbiter_2m

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of cycles a granted slave access may wait for s_mem_ready before it is aborted (legal range 1..255).
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF, SHALL be the read data returned to the master on an aborted access.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 m0_mem_valid / m1_mem_valid  input  1 each  request valid from master 0 (CPU) and master 1 (debug/DMA).
REQ-006 m0_mem_addr, m0_mem_wdata / m1_mem_addr, m1_mem_wdata  input  32 each  request address and write data.
REQ-007 m0_mem_wstrb / m1_mem_wstrb  input  4 each  byte write strobes; 4'b0000 means read.
REQ-008 m0_mem_ready / m1_mem_ready  output  1 each  one-cycle completion pulse to the owning master.
REQ-009 m0_mem_rdata / m1_mem_rdata  output  32 each  read data, valid while the matching ready is high.
REQ-010 s_mem_valid, s_mem_addr[31:0], s_mem_wdata[31:0], s_mem_wstrb[3:0]  output  request to the shared slave bus (GPIO, RAM, ...).
REQ-011 s_mem_ready  input  1, s_mem_rdata  input  32  slave completion and read data.
REQ-012 err_timeout  output  1  sticky flag, set on any aborted access.
REQ-013 err_master  output  1  index of the master whose access was last aborted.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT0, GRANT1 and ABORT.
REQ-015 In IDLE, at most one master SHALL be granted per cycle, and the grant SHALL take effect on the next clock edge.
REQ-016 With exactly one mN_mem_valid high, the FSM SHALL move to GRANTN.
REQ-017 With both valids high, the master not served last SHALL be granted (round-robin); after reset, master 0 SHALL have priority.
REQ-018 In GRANTN, s_mem_valid SHALL equal mN_mem_valid, and s_mem_addr, s_mem_wdata and s_mem_wstrb SHALL be the master N signals, combinationally.
REQ-019 In GRANTN, mN_mem_ready SHALL equal s_mem_ready and mN_mem_rdata SHALL equal s_mem_rdata.
REQ-020 The non-granted master's ready SHALL be 0.
REQ-021 Outside a GRANT state, s_mem_valid SHALL be 0, s_mem_wstrb SHALL be 0, and the other s_* outputs SHALL be don't-care (drive 0).
REQ-022 On s_mem_ready=1 in GRANTN, the FSM SHALL return to IDLE, record last=N and clear the timeout counter.
REQ-023 A grant SHALL be held until completion or abort; no preemption.
REQ-024 An 8-bit wait counter SHALL count cycles spent in GRANTN with s_mem_ready=0.
REQ-025 When the wait counter reaches TIMEOUT_CYCLES, the FSM SHALL enter ABORT.
REQ-026 ABORT SHALL last one cycle and drive s_mem_valid=0 and mN_mem_ready=1 with mN_mem_rdata=ERR_RDATA.
REQ-027 On entering ABORT, err_timeout SHALL be set to 1, err_master SHALL be set to N, and last SHALL be set to N; ABORT then returns to IDLE.
REQ-028 If s_mem_ready rises in the same cycle the counter reaches TIMEOUT_CYCLES, completion SHALL win: no abort and no error.
REQ-029 If the granted master drops valid before ready (illegal), the FSM SHALL return to IDLE on the next edge with no ready pulse.
REQ-030 Total latency from mN_mem_valid to s_mem_valid SHALL be 1 cycle; there SHALL be no added latency on the ready/rdata return path.
REQ-031 err_timeout SHALL clear only on reset.

Reset
REQ-032 Asserting resetn=0 SHALL asynchronously force state=IDLE, last=1 (so master 0 wins first), wait counter=0, err_timeout=0 and err_master=0.
REQ-033 Consequently all ready outputs and s_mem_valid SHALL be 0 during reset.
REQ-034 Reset mid-transfer SHALL drop s_mem_valid immediately, with no ready pulse to either master.

Structure
REQ-035 FSM state encoding (2-bit enum) and the ERR_RDATA default SHALL live in the shared package mem_bus_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the round-robin pick is inline logic.

Verification
REQ-037 Single master: m0 writes 32'h0000_00A5 with wstrb=4'hF to a 1-cycle-ready slave -> s_mem_valid 1 cycle after m0 valid, m0_mem_ready pulses once, m1_mem_ready stays 0.
REQ-038 Contention: m0 and m1 valid together from reset -> m0 is served first, then m1; repeated back-to-back requests alternate m0, m1, m0.
REQ-039 Read: m1 reads while the slave returns 32'h1234_5678 -> m1_mem_rdata is 32'h1234_5678 in its ready cycle.
REQ-040 Timeout: slave never readies, TIMEOUT_CYCLES=4 -> after 4 wait cycles m0_mem_ready=1 with rdata 32'hDEAD_BEEF, err_timeout=1, err_master=0.
REQ-041 Race: s_mem_ready arrives exactly at count 4 -> normal completion and err_timeout remains 0.
REQ-042 Reset mid-grant: resetn asserted while in GRANT1 -> s_mem_valid=0 immediately; after release, m0 wins a simultaneous request.
